multicycle_controller: RTL and testbench

- Multi-cycle sequencing FSM for the RISC-V RV32I core.
- Drives the shared datapath (PC, IR, register file, ALU, unified memory port) through fetch, decode, execute, memory and writeback steps, one instruction at a time.
- Handles memory wait-states through a ready handshake, traps on illegal opcodes and memory timeouts, and counts retired instructions.

---
 rtl/multicycle_controller.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for an RV32I core: steers PC, IR, register file,
// ALU and the shared memory port, with wait-state timeout and illegal-opcode traps.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSel,
  output logic             regWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemAddrSel,
  output logic             immSelMux,
  output logic [1:0]       ResultSel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  state_t            state, state_next;
  logic [6:0]        opcode_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              timed_out;
  logic              retire;
  logic [1:0]        cause_next;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JALR, OP_JAL, OP_LUI, OP_AUIPC: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

  // A ready in the same cycle the counter hits the limit still completes the access.
  assign waiting   = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
  assign timed_out = waiting && (wait_cnt == WAIT_W'(MEM_TIMEOUT));
  assign state_o   = state;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next = state;
    retire     = 1'b0;
    cause_next = 2'b00;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSel      = 2'b00;
    regWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemAddrSel = 1'b0;
    immSelMux  = 1'b0;
    ResultSel  = 2'b00;

    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        if (timed_out) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end else if (mem_ready) begin
          IRWrite    = 1'b1;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_legal(Opcode)) begin
          state_next = S_EXECUTE;
        end else begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end
      end

      S_EXECUTE: begin
        immSelMux = (opcode_q != OP_R) && (opcode_q != OP_BRANCH);
        case (opcode_q)
          OP_BRANCH: begin
            PCWrite    = 1'b1;
            PCSel      = branch_taken ? 2'b01 : 2'b00;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          OP_LOAD, OP_STORE: state_next = S_MEM;
          default:           state_next = S_WRITEBACK;
        endcase
      end

      S_MEM: begin
        MemAddrSel = 1'b1;
        MemRead    = (opcode_q == OP_LOAD);
        MemWrite   = (opcode_q == OP_STORE);
        if (timed_out) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end else if (mem_ready) begin
          if (opcode_q == OP_LOAD) begin
            state_next = S_WRITEBACK;
          end else begin
            PCWrite    = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
        end
      end

      S_WRITEBACK: begin
        regWrite   = 1'b1;
        PCWrite    = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
        if (opcode_q == OP_LOAD) begin
          ResultSel = 2'b01;
        end else if ((opcode_q == OP_JAL) || (opcode_q == OP_JALR)) begin
          ResultSel = 2'b10;
        end
        if (opcode_q == OP_JAL) begin
          PCSel = 2'b01;
        end else if (opcode_q == OP_JALR) begin
          PCSel = 2'b10;
        end
      end

      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase

    // Reset aborts any access at once, before the state register has even been cleared.
    if (reset) begin
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCSel      = 2'b00;
      regWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemAddrSel = 1'b0;
      immSelMux  = 1'b0;
      ResultSel  = 2'b00;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_FETCH;
      opcode_q      <= 7'd0;
      wait_cnt      <= '0;
      retired_count <= '0;
      trap          <= 1'b0;
      trap_cause    <= 2'b00;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        opcode_q <= Opcode;
      end
      if (waiting && (state_next == state)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (retire) begin
        retired_count <= retired_count + CNT_W'(1);
      end
      if ((state_next == S_TRAP) && (state != S_TRAP)) begin
        trap       <= 1'b1;
        trap_cause <= cause_next;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: instruction-level reference model expands each instruction
// into its expected per-cycle control pattern and compares against the controller.
module tb_multicycle_controller;

  localparam int TO = 16;
  localparam int CW = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    Opcode = 7'd0;
  logic          mem_ready = 1'b0;
  logic          branch_taken = 1'b0;
  logic          IRWrite, PCWrite, regWrite, MemRead, MemWrite, MemAddrSel, immSelMux, trap;
  logic [1:0]    PCSel, ResultSel, trap_cause;
  logic [2:0]    state_o;
  logic [CW-1:0] retired_count;

  multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSel(PCSel),
    .regWrite(regWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemAddrSel(MemAddrSel),
    .immSelMux(immSelMux), .ResultSel(ResultSel), .trap(trap), .trap_cause(trap_cause),
    .state_o(state_o), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       irw;
    logic       pcw;
    logic [1:0] pcsel;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       mas;
    logic       imm;
    logic [1:0] rs;
    logic       trp;
    logic [1:0] cause;
  } exp_t;

  typedef struct {
    exp_t e;
    bit   rc;   // mem_ready value is forced this cycle
    bit   rv;   // forced mem_ready value
    bit   ret;  // instruction retires at the end of this cycle
  } cyc_t;

  int         vectors = 0;
  int         miscompares = 0;
  int         rc_model = 0;
  logic       trap_model = 1'b0;
  logic [1:0] cause_model = 2'b00;
  cyc_t       sched[$];
  logic [6:0] legal_ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                 OP_JALR, OP_JAL, OP_LUI, OP_AUIPC};

  function automatic bit legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic cyc_t mk(input logic [2:0] st, input bit rc, input bit rv);
    cyc_t c;
    c.e = '0;
    c.e.st = st;
    c.e.trp = trap_model;
    c.e.cause = cause_model;
    c.rc = rc;
    c.rv = rv;
    c.ret = 1'b0;
    return c;
  endfunction

  // Fetch with fw wait cycles, then decode.
  function automatic void build_front(input int fw);
    cyc_t c;
    for (int i = 0; i <= fw; i++) begin
      c = mk(3'd0, 1'b1, i == fw);
      c.e.mr = 1'b1;
      c.e.irw = (i == fw);
      sched.push_back(c);
    end
    sched.push_back(mk(3'd1, 1'b0, 1'b0));
  endfunction

  function automatic void build_legal(input logic [6:0] op, input int fw, input int mw, input logic bt);
    cyc_t c;
    bit ld = (op == OP_LOAD);
    bit stv = (op == OP_STORE);
    build_front(fw);
    c = mk(3'd2, 1'b0, 1'b0);
    c.e.imm = !((op == OP_R) || (op == OP_BRANCH));
    if (op == OP_BRANCH) begin
      c.e.pcw = 1'b1;
      c.e.pcsel = bt ? 2'b01 : 2'b00;
      c.ret = 1'b1;
      sched.push_back(c);
      return;
    end
    sched.push_back(c);
    if (ld || stv) begin
      for (int i = 0; i <= mw; i++) begin
        c = mk(3'd3, 1'b1, i == mw);
        c.e.mas = 1'b1;
        c.e.mr = ld;
        c.e.mw = stv;
        if (stv && i == mw) begin
          c.e.pcw = 1'b1;
          c.ret = 1'b1;
        end
        sched.push_back(c);
      end
      if (stv) return;
    end
    c = mk(3'd4, 1'b0, 1'b0);
    c.e.rw = 1'b1;
    c.e.pcw = 1'b1;
    c.e.rs = ld ? 2'b01 : ((op == OP_JAL || op == OP_JALR) ? 2'b10 : 2'b00);
    c.e.pcsel = (op == OP_JAL) ? 2'b01 : ((op == OP_JALR) ? 2'b10 : 2'b00);
    c.ret = 1'b1;
    sched.push_back(c);
  endfunction

  function automatic void build_trap_tail(input logic [1:0] cause, input int n);
    trap_model = 1'b1;
    cause_model = cause;
    for (int i = 0; i < n; i++) sched.push_back(mk(3'd5, 1'b0, 1'b0));
  endfunction

  // Drive each scheduled cycle at the falling edge and compare once outputs settle.
  task automatic run_sched(input string name, input logic [6:0] op, input logic bt);
    exp_t got;
    foreach (sched[i]) begin
      @(negedge clk);
      Opcode = (sched[i].e.st == 3'd1) ? op : 7'($urandom);
      mem_ready = sched[i].rc ? sched[i].rv : 1'($urandom);
      branch_taken = (sched[i].e.st == 3'd2) ? bt : 1'($urandom);
      #1;
      got = {state_o, IRWrite, PCWrite, PCSel, regWrite, MemRead, MemWrite, MemAddrSel,
             immSelMux, ResultSel, trap, trap_cause};
      vectors++;
      if ({got, retired_count} !== {sched[i].e, rc_model[CW-1:0]}) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got state=%0d ctl=%b count=%0d, expected state=%0d ctl=%b count=%0d",
                 name, i, got.st, got, retired_count, sched[i].e.st, sched[i].e, rc_model[CW-1:0]);
      end
      if (sched[i].ret) rc_model++;
    end
    sched.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rc_model = 0;
    trap_model = 1'b0;
    cause_model = 2'b00;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      Opcode = 7'($urandom);
      mem_ready = 1'($urandom);
      branch_taken = 1'($urandom);
      #1;
      vectors++;
      if ({state_o, IRWrite, PCWrite, PCSel, regWrite, MemRead, MemWrite, MemAddrSel, immSelMux,
           ResultSel, trap, trap_cause, retired_count} !== '0) begin
        miscompares++;
        $display("FAIL reset: got state=%0d MemRead=%b trap=%b cause=%b count=%0d, expected all zero",
                 state_o, MemRead, trap, trap_cause, retired_count);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    build_legal(OP_R, 0, 0, 1'b0);
    run_sched("rtype", OP_R, 1'b0);
  endtask

  task automatic test_load_wait();
    build_legal(OP_LOAD, 0, 3, 1'b0);
    run_sched("load_wait", OP_LOAD, 1'b0);
  endtask

  task automatic test_branch();
    build_legal(OP_BRANCH, 0, 0, 1'b1);
    run_sched("branch_taken", OP_BRANCH, 1'b1);
    build_legal(OP_BRANCH, 1, 0, 1'b0);
    run_sched("branch_not_taken", OP_BRANCH, 1'b0);
  endtask

  task automatic test_jumps();
    build_legal(OP_JALR, 0, 0, 1'b0);
    run_sched("jalr", OP_JALR, 1'b0);
    build_legal(OP_JAL, 2, 0, 1'b0);
    run_sched("jal", OP_JAL, 1'b0);
  endtask

  task automatic test_ready_boundary();
    build_legal(OP_LOAD, TO, TO, 1'b0);
    run_sched("ready_at_limit_load", OP_LOAD, 1'b0);
    build_legal(OP_STORE, TO - 1, TO, 1'b0);
    run_sched("ready_at_limit_store", OP_STORE, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [6:0] op = legal_ops[$urandom_range(0, 8)];
      int fw = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 3);
      int mw = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 3);
      logic bt = 1'($urandom);
      build_legal(op, fw, mw, bt);
      run_sched("random", op, bt);
    end
  endtask

  task automatic test_fetch_timeout();
    pulse_reset();
    build_legal(OP_R, 0, 0, 1'b0);
    run_sched("pre_timeout_rtype", OP_R, 1'b0);
    for (int i = 0; i <= TO; i++) begin
      cyc_t c = mk(3'd0, 1'b1, 1'b0);
      c.e.mr = 1'b1;
      sched.push_back(c);
    end
    build_trap_tail(2'b10, 6);
    run_sched("fetch_timeout", OP_R, 1'b0);
  endtask

  task automatic test_mem_timeout();
    pulse_reset();
    build_front(0);
    begin
      cyc_t c = mk(3'd2, 1'b0, 1'b0);
      c.e.imm = 1'b1;
      sched.push_back(c);
      for (int i = 0; i <= TO; i++) begin
        c = mk(3'd3, 1'b1, 1'b0);
        c.e.mas = 1'b1;
        c.e.mw = 1'b1;
        sched.push_back(c);
      end
    end
    build_trap_tail(2'b10, 4);
    run_sched("mem_timeout", OP_STORE, 1'b0);
  endtask

  task automatic test_illegal();
    logic [6:0] op;
    pulse_reset();
    build_front(0);
    build_trap_tail(2'b01, 20);
    run_sched("illegal_1111111", 7'b1111111, 1'b0);
    pulse_reset();
    do op = 7'($urandom); while (legal(op));
    build_front(2);
    build_trap_tail(2'b01, 3);
    run_sched("illegal_random", op, 1'b0);
  endtask

  task automatic test_reset_mid_mem();
    pulse_reset();
    build_legal(OP_STORE, 0, 5, 1'b0);
    sched = sched[0:3];
    run_sched("store_before_reset", OP_STORE, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    vectors++;
    if ({state_o, MemWrite, MemRead, MemAddrSel, PCWrite} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_mid_mem: got state=%0d MemWrite=%b MemRead=%b MemAddrSel=%b, expected 0 0 0 0",
               state_o, MemWrite, MemRead, MemAddrSel);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    rc_model = 0;
    trap_model = 1'b0;
    cause_model = 2'b00;
    build_legal(OP_AUIPC, 1, 0, 1'b0);
    run_sched("after_reset_auipc", OP_AUIPC, 1'b0);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_jumps();
    test_ready_boundary();
    test_random();
    test_fetch_timeout();
    test_mem_timeout();
    test_illegal();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
